qa_drv_hc_rx_fifo: RTL and testbench

// - To-client (host->FPGA) channel buffer; sits directly upstream of the host-channel tester and drives its rx_data/rx_rdy/rx_enable port.
// - Accepts cache-line read responses from the host ring reader into a show-ahead FIFO.
// - Tracks slot reservations so read requests are issued only when space is guaranteed.
// - Emits credit-return pulses so the driver can advance the host-visible consumer pointer.
//

---
 rtl/qa_drv_hc_rx_fifo_pkg.sv | 14 +
 rtl/qa_drv_hc_sdp_ram.sv | 25 ++
 rtl/qa_drv_hc_rx_fifo.sv | 102 ++++++++++
 tb/tb_qa_drv_hc_rx_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qa_drv_hc_rx_fifo_pkg.sv
// Shared types for the host-channel rx FIFO: cache-line payload, error flags, credit width.
// No logic; imported by the FIFO top and its RAM.
package qa_drv_hc_rx_fifo_pkg;

   typedef logic [511:0] t_cci_cldata;

   localparam int QA_DRV_HC_RX_FIFO_CREDIT_W = 16;

   typedef struct packed {
      logic rd_empty;    // [1] dequeue while empty
      logic wr_no_res;   // [0] write with no outstanding reservation
   } t_qa_drv_hc_rx_fifo_err;

endpackage

// File: rtl/qa_drv_hc_sdp_ram.sv
// Simple dual-port line store: synchronous write, asynchronous read, array not reset.
// Read data follows rd_addr in the same cycle; no flow control of its own.
module qa_drv_hc_sdp_ram
   import qa_drv_hc_rx_fifo_pkg::*;
#(
   parameter int DEPTH = 64
)
(
   input  logic                              clk,
   input  logic                              wr_en,
   input  logic [$clog2(DEPTH)-1:0]          wr_addr,
   input  logic [$bits(t_cci_cldata)-1:0]    wr_data,
   input  logic [$clog2(DEPTH)-1:0]          rd_addr,
   output logic [$bits(t_cci_cldata)-1:0]    rd_data
);

   t_cci_cldata mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/qa_drv_hc_rx_fifo.sv
// Host->FPGA show-ahead line FIFO with slot reservation and consumer credit return.
// Write visible on rx_data one cycle later; reads gated by rx_rdy, requests gated by space_avail.
module qa_drv_hc_rx_fifo
   import qa_drv_hc_rx_fifo_pkg::*;
#(
   parameter int N_ENTRIES     = 64,
   parameter int CREDIT_THRESH = 16
)
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_reserve,
   output logic                        space_avail,
   input  logic                        wr_en,
   input  logic [511:0]                wr_data,
   output logic [511:0]                rx_data,
   output logic                        rx_rdy,
   input  logic                        rx_enable,
   input  logic                        credit_flush,
   output logic                        credit_return,
   output logic [15:0]                 credit_count,
   output logic [$clog2(N_ENTRIES):0]  fifo_count,
   output logic [1:0]                  err_sticky
);

   localparam int AW = $clog2(N_ENTRIES);
   localparam int PW = AW + 1;
   localparam int CW = QA_DRV_HC_RX_FIFO_CREDIT_W;

   logic [PW-1:0] wr_ptr, rd_ptr, pending;
   logic [PW-1:0] count_cur, count_nxt, pending_nxt;
   logic [PW:0]   committed_nxt;
   logic          empty, full, rd_ok, wr_ok, res_ok, wr_consumes;
   logic [CW-1:0] consumed, consumed_inc;
   logic          credit_fire;
   t_qa_drv_hc_rx_fifo_err err_q, err_nxt;

   always_comb begin
      count_cur   = wr_ptr - rd_ptr;
      empty       = (wr_ptr == rd_ptr);
      full        = (count_cur == PW'(N_ENTRIES));
      rd_ok       = rx_enable && !empty;
      // A dequeue in the same cycle frees the slot a write at full lands in.
      wr_ok       = wr_en && (!full || rd_ok);
      res_ok      = req_reserve && space_avail;
      wr_consumes = wr_en && (pending != '0);

      count_nxt     = count_cur + PW'(wr_ok) - PW'(rd_ok);
      pending_nxt   = pending + PW'(res_ok) - PW'(wr_consumes);
      committed_nxt = {1'b0, count_nxt} + {1'b0, pending_nxt};

      consumed_inc = consumed + CW'(rd_ok);
      credit_fire  = (consumed_inc >= CW'(CREDIT_THRESH)) ||
                     (credit_flush && (consumed_inc != '0));

      err_nxt = err_q;
      if (wr_en && (pending == '0)) err_nxt.wr_no_res = 1'b1;
      if (rx_enable && empty)       err_nxt.rd_empty  = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         pending       <= '0;
         space_avail   <= 1'b1;
         consumed      <= '0;
         credit_return <= 1'b0;
         credit_count  <= '0;
         err_q         <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         pending       <= pending_nxt;
         space_avail   <= (committed_nxt < (PW+1)'(N_ENTRIES));
         credit_return <= credit_fire;
         err_q         <= err_nxt;
         if (credit_fire) begin
            credit_count <= consumed_inc;
            consumed     <= '0;
         end else begin
            consumed     <= consumed_inc;
         end
      end
   end

   qa_drv_hc_sdp_ram #(
      .DEPTH (N_ENTRIES)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (wr_data),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (rx_data)
   );

   assign rx_rdy     = !empty;
   assign fifo_count = count_cur;
   assign err_sticky = err_q;

endmodule

// File: tb/tb_qa_drv_hc_rx_fifo.sv
// Directed bench for qa_drv_hc_rx_fifo: vector table for basic flow, sequences for fill/wrap/credit/reset.
module tb_qa_drv_hc_rx_fifo;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req_reserve = 1'b0;
   logic         space_avail;
   logic         wr_en = 1'b0;
   logic [511:0] wr_data = '0;
   logic [511:0] rx_data;
   logic         rx_rdy;
   logic         rx_enable = 1'b0;
   logic         credit_flush = 1'b0;
   logic         credit_return;
   logic [15:0]  credit_count;
   logic [6:0]   fifo_count;
   logic [1:0]   err_sticky;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   qa_drv_hc_rx_fifo #(.N_ENTRIES(64), .CREDIT_THRESH(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_reserve   (req_reserve),
      .space_avail   (space_avail),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .rx_data       (rx_data),
      .rx_rdy        (rx_rdy),
      .rx_enable     (rx_enable),
      .credit_flush  (credit_flush),
      .credit_return (credit_return),
      .credit_count  (credit_count),
      .fifo_count    (fifo_count),
      .err_sticky    (err_sticky)
   );

   typedef struct packed {
      logic       rr, we;
      logic [7:0] wd;
      logic       re, cf;
      logic       e_rdy, e_space;
      logic [7:0] e_cnt;
      logic [1:0] e_err;
      logic       e_cr;
      logic [15:0] e_cc;
      logic [7:0] e_data;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: inputs applied at negedge, outputs sampled 1ns after the posedge.
   task automatic step(input logic rr, input logic we, input logic [7:0] wd,
                       input logic re, input logic cf);
      @(negedge clk);
      req_reserve  = rr;
      wr_en        = we;
      wr_data      = {64{wd}};
      rx_enable    = re;
      credit_flush = cf;
      @(posedge clk);
      #1;
      req_reserve  = 1'b0;
      wr_en        = 1'b0;
      rx_enable    = 1'b0;
      credit_flush = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic vec_t mk(logic rr, logic we, logic [7:0] wd, logic re, logic cf,
                               logic e_rdy, logic [7:0] e_cnt, logic [1:0] e_err,
                               logic e_cr, logic [15:0] e_cc, logic [7:0] e_data);
      vec_t v;
      v.rr = rr; v.we = we; v.wd = wd; v.re = re; v.cf = cf;
      v.e_rdy = e_rdy; v.e_space = 1'b1; v.e_cnt = e_cnt; v.e_err = e_err;
      v.e_cr = e_cr; v.e_cc = e_cc; v.e_data = e_data;
      return v;
   endfunction

   initial begin
      logic [7:0] q[$];
      int seq;
      int pulses;
      logic [15:0] last_cc;

      //         rr  we  wd     re  cf  rdy cnt err    cr  cc  data
      vecs[0] = mk(1, 0, 8'h00, 0, 0,  0,  0, 2'b00, 0,  0, 8'h00);
      vecs[1] = mk(0, 1, 8'hA5, 0, 0,  1,  1, 2'b00, 0,  0, 8'hA5);
      vecs[2] = mk(0, 0, 8'h00, 1, 0,  0,  0, 2'b00, 0,  0, 8'h00);
      vecs[3] = mk(0, 1, 8'h3C, 0, 0,  1,  1, 2'b01, 0,  0, 8'h3C);
      vecs[4] = mk(0, 0, 8'h00, 1, 0,  0,  0, 2'b01, 0,  0, 8'h00);
      vecs[5] = mk(0, 0, 8'h00, 1, 0,  0,  0, 2'b11, 0,  0, 8'h00);
      vecs[6] = mk(0, 0, 8'h00, 0, 0,  0,  0, 2'b11, 0,  0, 8'h00);
      vecs[7] = mk(0, 0, 8'h00, 0, 1,  0,  0, 2'b11, 1,  2, 8'h00);
      vecs[8] = mk(0, 0, 8'h00, 0, 0,  0,  0, 2'b11, 0,  2, 8'h00);
      vecs[9] = mk(0, 0, 8'h00, 0, 1,  0,  0, 2'b11, 0,  2, 8'h00);

      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_rx_rdy", rx_rdy, 1'b0);
      check("rst_space", space_avail, 1'b1);
      check("rst_count", fifo_count, 0);
      check("rst_credit_return", credit_return, 1'b0);
      check("rst_credit_count", credit_count, 0);
      check("rst_err", err_sticky, 2'b00);

      // Basic flow, error flags, small flush
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].rr, vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].cf);
         check($sformatf("v%0d_rx_rdy", i), rx_rdy, vecs[i].e_rdy);
         check($sformatf("v%0d_space", i), space_avail, vecs[i].e_space);
         check($sformatf("v%0d_count", i), fifo_count, vecs[i].e_cnt);
         check($sformatf("v%0d_err", i), err_sticky, vecs[i].e_err);
         check($sformatf("v%0d_credit_return", i), credit_return, vecs[i].e_cr);
         check($sformatf("v%0d_credit_count", i), credit_count, vecs[i].e_cc);
         if (vecs[i].e_rdy) check($sformatf("v%0d_rx_data", i), rx_data, {64{vecs[i].e_data}});
      end

      do_reset();
      #1;
      check("err_cleared_by_reset", err_sticky, 2'b00);
      check("credit_count_cleared", credit_count, 0);

      // Reserve every slot, one extra reserve that must be ignored, then fill
      for (int i = 0; i < 64; i++) begin
         step(1, 0, 8'h00, 0, 0);
         if (i == 62) check("space_after_63_reserves", space_avail, 1'b1);
      end
      check("space_after_64_reserves", space_avail, 1'b0);
      step(1, 0, 8'h00, 0, 0);
      check("space_after_65th_reserve", space_avail, 1'b0);
      seq = 0;
      for (int i = 0; i < 64; i++) begin
         step(0, 1, 8'(seq), 0, 0);
         q.push_back(8'(seq));
         seq++;
      end
      check("fill_count", fifo_count, 64);
      check("fill_err", err_sticky, 2'b00);
      check("fill_head", rx_data, {64{q[0]}});
      step(0, 0, 8'h00, 1, 0);
      void'(q.pop_front());
      check("space_after_one_read", space_avail, 1'b1);
      check("count_after_one_read", fifo_count, 63);
      step(1, 0, 8'h00, 0, 0);
      check("space_after_refill_reserve", space_avail, 1'b0);
      step(0, 1, 8'(seq), 0, 0);
      q.push_back(8'(seq));
      seq++;
      check("refull_count", fifo_count, 64);

      // Streaming at full: the reserve is refused (no free slot), so every write flags err[0]
      for (int i = 0; i < 135; i++) begin
         check("stream_head", rx_data, {64{q[0]}});
         step(1, 1, 8'(seq), 1, 0);
         void'(q.pop_front());
         q.push_back(8'(seq));
         seq++;
      end
      check("stream_count", fifo_count, 64);
      check("stream_err", err_sticky, 2'b01);
      check("stream_space", space_avail, 1'b0);
      check("lines_written", seq, 200);
      for (int i = 0; i < 64; i++) begin
         check("drain_head", rx_data, {64{q[0]}});
         step(0, 0, 8'h00, 1, 0);
         void'(q.pop_front());
      end
      check("drain_count", fifo_count, 0);
      check("drain_rx_rdy", rx_rdy, 1'b0);

      // Credit threshold and flush
      do_reset();
      for (int i = 0; i < 21; i++) step(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 21; i++) step(0, 1, 8'(i), 0, 0);
      check("credit_fill_count", fifo_count, 21);
      pulses = 0;
      last_cc = '0;
      for (int i = 0; i < 18; i++) begin
         step(0, 0, 8'h00, (i < 16), 0);
         if (credit_return) begin
            pulses++;
            last_cc = credit_count;
         end
      end
      check("thresh_pulses", pulses, 1);
      check("thresh_count", last_cc, 16);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 8'h00, (i < 5), 0);
         if (credit_return) pulses++;
      end
      check("partial_no_pulse", pulses, 0);
      step(0, 0, 8'h00, 0, 1);
      check("flush_pulse", credit_return, 1'b1);
      check("flush_count", credit_count, 5);
      step(0, 0, 8'h00, 0, 0);
      check("flush_single_cycle", credit_return, 1'b0);
      check("credit_err_clean", err_sticky, 2'b00);

      // Asynchronous reset with stored lines and outstanding reservations
      do_reset();
      for (int i = 0; i < 13; i++) step(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 8'(i + 50), 0, 0);
      check("pre_reset_count", fifo_count, 10);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_rx_rdy", rx_rdy, 1'b0);
      check("async_count", fifo_count, 0);
      @(negedge clk);
      reset = 1'b0;
      step(0, 0, 8'h00, 0, 0);
      check("post_reset_rx_rdy", rx_rdy, 1'b0);
      check("post_reset_space", space_avail, 1'b1);
      check("post_reset_count", fifo_count, 0);
      check("post_reset_no_credit", credit_return, 1'b0);
      for (int i = 0; i < 63; i++) step(1, 0, 8'h00, 0, 0);
      check("reservations_discarded", space_avail, 1'b1);
      step(1, 0, 8'h00, 0, 0);
      check("reserve_full_after_reset", space_avail, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
